esc_reg_pipe: RTL and testbench
===============================

ESC_REG_PIPE -- requirements
Module: esc_reg_pipe

Interface
REQ-001 Parameter DW, default 32, width of write-data payload.
REQ-002 Parameter AW, default 5, width of destination-register index.
REQ-003 Parameter DEPTH, default 3, number of pipeline stages carried (legal 1..8).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hold all stages.
REQ-007 flush  input  1  kill all in-flight write enables.
REQ-008 sel  input  1  force write enable to 1 for the entering instruction.
REQ-009 senial  input  1  decoded write enable of the entering instruction.
REQ-010 rd_in  input  AW  destination register of the entering instruction.
REQ-011 wd_in  input  DW  write data of the entering instruction.
REQ-012 esc_reg  output  1  registered write enable at last stage (writeback).
REQ-013 rd_out  output  AW  destination register at last stage.
REQ-014 wd_out  output  DW  write data at last stage.
REQ-015 stage_en  output  DEPTH  write enable of each stage, bit 0 youngest.

Function
REQ-016 Entering enable SHALL be (sel ? 1 : senial) AND (rd_in != 0); register 0 is never written.
REQ-017 Unstalled cycle: stage 0 captures {enable, rd_in, wd_in}; stage i captures stage i-1; latency DEPTH cycles input-to-esc_reg.
REQ-018 stall=1: every stage holds its full contents; inputs ignored.
REQ-019 flush=1: every stage_en bit cleared next edge; rd/wd fields may retain values; entering instruction also discarded.
REQ-020 Priority reset > flush > stall > shift; stall and flush together behave as flush.
REQ-021 esc_reg, rd_out, wd_out SHALL be driven directly from the last stage's flops (no combinational path from inputs).
REQ-022 DEPTH=1: single stage; same rules apply.

Reset
REQ-023 On reset edge: all stage_en bits, esc_reg = 0, rd_out = 0, wd_out = 0, all internal rd/wd fields = 0.
REQ-024 Reset asserted mid-operation discards all in-flight entries; first post-reset input appears at esc_reg DEPTH cycles after its capture.

Configuration
REQ-025 Macro ESC_REG_FWD_EN, when defined, adds inputs rs_q [AW] and outputs fwd_hit [1], fwd_data [DW].
REQ-026 With ESC_REG_FWD_EN: fwd_hit = 1 when any stage i has stage_en[i]=1 and rd[i]==rs_q and rs_q!=0; fwd_data = wd of the youngest matching stage; combinational from flops and rs_q; fwd_data = 0 when no hit.
REQ-027 Without ESC_REG_FWD_EN: those ports and compare logic SHALL not exist; remaining behaviour identical.

Structure
REQ-028 Shared package holds default DW, AW, DEPTH constants, ZERO_REG index constant, and the stage-entry record typedef {en, rd, wd}.
REQ-029 One sub-module esc_reg_stage: one stage register with reset, flush, stall, load; instantiated DEPTH times via generate.

Verification
REQ-030 Reset, then sel=0, senial=1, rd_in=7, wd_in=0xDEAD_BEEF -> after 3 cycles esc_reg=1, rd_out=7, wd_out=0xDEADBEEF; prior cycles esc_reg=0.
REQ-031 sel=1, senial=0, rd_in=3 -> esc_reg=1 at cycle 3; sel=1, rd_in=0 -> esc_reg=0 at cycle 3.
REQ-032 Issue rd 1,2,3 back-to-back, stall 2 cycles after the second -> stage_en/rd stable during stall; rd_out sequence 1,2,3 with 2-cycle gap before 3's predecessor resumes; no entry lost or duplicated.
REQ-033 Three valid entries in flight, assert flush and stall together one cycle -> stage_en=000 next cycle, esc_reg=0 for following 3 cycles absent new inputs.
REQ-034 Valid entry at stage 1, reset asserted -> next cycle all outputs 0; stage_en=000.
REQ-035 ESC_REG_FWD_EN: stage 0 rd=5 wd=0x11, stage 2 rd=5 wd=0x22, rs_q=5 -> fwd_hit=1, fwd_data=0x11; rs_q=0 -> fwd_hit=0, fwd_data=0.

Source files
------------

// File: rtl/esc_reg_pipe_pkg.sv
// Shared constants and the stage-entry record for the esc_reg_pipe writeback pipeline.
// ESC_REG_FWD_EN (optional macro) enables the forwarding compare in esc_reg_pipe.
package esc_reg_pipe_pkg;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 5;
    localparam int DEPTH_DEF = 3;
    localparam int ZERO_REG  = 0;

    typedef struct packed {
        logic              en;
        logic [AW_DEF-1:0] rd;
        logic [DW_DEF-1:0] wd;
    } stage_entry_t;

endpackage

// File: rtl/esc_reg_pipe_if.sv
// Bus bundle between the pipeline control/issue side and esc_reg_pipe.
// ESC_REG_FWD_EN adds the forwarding query (rs_q) and result (fwd_hit, fwd_data).
interface esc_reg_pipe_if
    import esc_reg_pipe_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) ();

    logic             stall;
    logic             flush;
    logic             sel;
    logic             senial;
    logic [AW-1:0]    rd_in;
    logic [DW-1:0]    wd_in;
    logic             esc_reg;
    logic [AW-1:0]    rd_out;
    logic [DW-1:0]    wd_out;
    logic [DEPTH-1:0] stage_en;
`ifdef ESC_REG_FWD_EN
    logic [AW-1:0]    rs_q;
    logic             fwd_hit;
    logic [DW-1:0]    fwd_data;
`endif

    modport master (
        output stall, flush, sel, senial, rd_in, wd_in,
        input  esc_reg, rd_out, wd_out, stage_en
`ifdef ESC_REG_FWD_EN
        , output rs_q
        , input  fwd_hit, fwd_data
`endif
    );

    modport slave (
        input  stall, flush, sel, senial, rd_in, wd_in,
        output esc_reg, rd_out, wd_out, stage_en
`ifdef ESC_REG_FWD_EN
        , input  rs_q
        , output fwd_hit, fwd_data
`endif
    );

endinterface

// File: rtl/esc_reg_stage.sv
// One pipeline stage register holding {en, rd, wd}.
// Priority: reset > flush > stall > load.
module esc_reg_stage
    import esc_reg_pipe_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          stall,
    input  logic          d_en,
    input  logic [AW-1:0] d_rd,
    input  logic [DW-1:0] d_wd,
    output logic          q_en,
    output logic [AW-1:0] q_rd,
    output logic [DW-1:0] q_wd
);

    // Flush only kills the enable; rd/wd are don't-care once en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_en <= 1'b0;
            q_rd <= '0;
            q_wd <= '0;
        end else if (flush) begin
            q_en <= 1'b0;
        end else if (!stall) begin
            q_en <= d_en;
            q_rd <= d_rd;
            q_wd <= d_wd;
        end
    end

endmodule

// File: rtl/esc_reg_pipe.sv
// Register-write-enable pipeline: carries {en, rd, wd} through DEPTH stages to writeback.
// Define ESC_REG_FWD_EN to add the rs_q forwarding compare (fwd_hit / fwd_data).
module esc_reg_pipe
    import esc_reg_pipe_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    esc_reg_pipe_if.slave bus
);

    logic             enter_en;
    logic [DEPTH-1:0] en_q;
    logic [AW-1:0]    rd_q [DEPTH];
    logic [DW-1:0]    wd_q [DEPTH];

    // Register 0 is hardwired, so an instruction targeting it never writes.
    assign enter_en = (bus.sel | bus.senial) & (bus.rd_in != AW'(ZERO_REG));

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic          d_en;
            logic [AW-1:0] d_rd;
            logic [DW-1:0] d_wd;

            if (i == 0) begin : g_head
                assign d_en = enter_en;
                assign d_rd = bus.rd_in;
                assign d_wd = bus.wd_in;
            end else begin : g_body
                assign d_en = en_q[i-1];
                assign d_rd = rd_q[i-1];
                assign d_wd = wd_q[i-1];
            end

            esc_reg_stage #(
                .DW (DW),
                .AW (AW)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .flush (bus.flush),
                .stall (bus.stall),
                .d_en  (d_en),
                .d_rd  (d_rd),
                .d_wd  (d_wd),
                .q_en  (en_q[i]),
                .q_rd  (rd_q[i]),
                .q_wd  (wd_q[i])
            );
        end
    endgenerate

    assign bus.esc_reg  = en_q[DEPTH-1];
    assign bus.rd_out   = rd_q[DEPTH-1];
    assign bus.wd_out   = wd_q[DEPTH-1];
    assign bus.stage_en = en_q;

`ifdef ESC_REG_FWD_EN
    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (en_q[i] && (rd_q[i] == bus.rs_q) && (bus.rs_q != AW'(ZERO_REG))) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = wd_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_esc_reg_pipe.sv
// Randomized + directed bench for esc_reg_pipe against a queue-style reference model.
// Also exercises the forwarding compare when built with ESC_REG_FWD_EN.
module tb_esc_reg_pipe;
    import esc_reg_pipe_pkg::*;

    localparam int D = DEPTH_DEF;

    logic clk;
    logic reset;

    int compared;
    int mismatched;

    stage_entry_t mdl [D];
    logic [AW_DEF-1:0] seen [$];

    esc_reg_pipe_if #(.DW(DW_DEF), .AW(AW_DEF), .DEPTH(D)) bus ();

    esc_reg_pipe #(.DW(DW_DEF), .AW(AW_DEF), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference: an array of entries that shifts as a whole unless held or killed.
    task automatic modelStep(input logic r, input logic st, input logic fl, input logic s,
                             input logic sn, input logic [AW_DEF-1:0] rd, input logic [DW_DEF-1:0] wd);
        if (r) begin
            for (int i = 0; i < D; i++) mdl[i] = '0;
        end else if (fl) begin
            for (int i = 0; i < D; i++) mdl[i].en = 1'b0;
        end else if (!st) begin
            for (int i = D - 1; i > 0; i--) mdl[i] = mdl[i-1];
            mdl[0].en = (s || sn) && (rd != ZERO_REG);
            mdl[0].rd = rd;
            mdl[0].wd = wd;
        end
    endtask

    task automatic checkModel();
        logic [D-1:0] exp_en;
        for (int i = 0; i < D; i++) exp_en[i] = mdl[i].en;
        checkOutput("esc_reg", 64'(bus.esc_reg), 64'(mdl[D-1].en));
        checkOutput("rd_out", 64'(bus.rd_out), 64'(mdl[D-1].rd));
        checkOutput("wd_out", 64'(bus.wd_out), 64'(mdl[D-1].wd));
        checkOutput("stage_en", 64'(bus.stage_en), 64'(exp_en));
`ifdef ESC_REG_FWD_EN
        begin
            logic              hit;
            logic [DW_DEF-1:0] data;
            hit  = 1'b0;
            data = '0;
            for (int i = 0; i < D; i++) begin
                if (!hit && mdl[i].en && mdl[i].rd == bus.rs_q && bus.rs_q != ZERO_REG) begin
                    hit  = 1'b1;
                    data = mdl[i].wd;
                end
            end
            checkOutput("fwd_hit", 64'(bus.fwd_hit), 64'(hit));
            checkOutput("fwd_data", 64'(bus.fwd_data), 64'(data));
        end
`endif
    endtask

    task automatic applyStimulus(input logic r, input logic st, input logic fl, input logic s,
                                 input logic sn, input logic [AW_DEF-1:0] rd, input logic [DW_DEF-1:0] wd);
        reset      = r;
        bus.stall  = st;
        bus.flush  = fl;
        bus.sel    = s;
        bus.senial = sn;
        bus.rd_in  = rd;
        bus.wd_in  = wd;
        @(posedge clk);
        modelStep(r, st, fl, s, sn, rd, wd);
        #1;
        checkModel();
        if (bus.esc_reg) seen.push_back(bus.rd_out);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic issue(input logic [AW_DEF-1:0] rd, input logic [DW_DEF-1:0] wd);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rd, wd);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        bus.stall  = 1'b0;
        bus.flush  = 1'b0;
        bus.sel    = 1'b0;
        bus.senial = 1'b0;
        bus.rd_in  = '0;
        bus.wd_in  = '0;
`ifdef ESC_REG_FWD_EN
        bus.rs_q   = '0;
`endif
        for (int i = 0; i < D; i++) mdl[i] = '0;

        doReset();
        doReset();
        checkOutput("rst_esc_reg", 64'(bus.esc_reg), 64'd0);
        checkOutput("rst_wd_out", 64'(bus.wd_out), 64'd0);
        checkOutput("rst_stage_en", 64'(bus.stage_en), 64'd0);

        // Basic latency: decoded enable, rd 7
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        checkOutput("lat_c1", 64'(bus.esc_reg), 64'd0);
        idle();
        checkOutput("lat_c2", 64'(bus.esc_reg), 64'd0);
        idle();
        checkOutput("lat_c3_en", 64'(bus.esc_reg), 64'd1);
        checkOutput("lat_c3_rd", 64'(bus.rd_out), 64'd7);
        checkOutput("lat_c3_wd", 64'(bus.wd_out), 64'hDEAD_BEEF);

        // Forced enable, and forced enable to register 0
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h3333);
        idle();
        idle();
        checkOutput("sel_rd3", 64'(bus.esc_reg), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h4444);
        idle();
        idle();
        checkOutput("sel_rd0", 64'(bus.esc_reg), 64'd0);

        // Stall in the middle of a burst: order preserved, nothing lost or duplicated
        doReset();
        seen.delete();
        issue(5'd1, 32'h1);
        issue(5'd2, 32'h2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h9);
        checkOutput("stall1_en", 64'(bus.stage_en), 64'b011);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h9);
        checkOutput("stall2_en", 64'(bus.stage_en), 64'b011);
        issue(5'd3, 32'h3);
        for (int i = 0; i < 4; i++) idle();
        checkOutput("stall_count", 64'(seen.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < seen.size()) checkOutput("stall_order", 64'(seen[i]), 64'(i + 1));
        end

        // Flush and stall together behave as flush
        doReset();
        issue(5'd1, 32'hA1);
        issue(5'd2, 32'hA2);
        issue(5'd3, 32'hA3);
        checkOutput("full_en", 64'(bus.stage_en), 64'b111);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 32'hA4);
        checkOutput("flush_en", 64'(bus.stage_en), 64'b000);
        for (int i = 0; i < 3; i++) begin
            idle();
            checkOutput("flush_quiet", 64'(bus.esc_reg), 64'd0);
        end

        // Reset mid-operation
        issue(5'd6, 32'hB6);
        idle();
        doReset();
        checkOutput("midrst_en", 64'(bus.stage_en), 64'd0);
        checkOutput("midrst_rd", 64'(bus.rd_out), 64'd0);
        checkOutput("midrst_wd", 64'(bus.wd_out), 64'd0);

`ifdef ESC_REG_FWD_EN
        // Youngest matching stage wins the forward
        doReset();
        issue(5'd5, 32'h22);
        issue(5'd9, 32'h33);
        bus.rs_q = 5'd5;
        issue(5'd5, 32'h11);
        checkOutput("fwd_hit5", 64'(bus.fwd_hit), 64'd1);
        checkOutput("fwd_data5", 64'(bus.fwd_data), 64'h11);
        bus.rs_q = 5'd0;
        #1;
        checkOutput("fwd_hit0", 64'(bus.fwd_hit), 64'd0);
        checkOutput("fwd_data0", 64'(bus.fwd_data), 64'd0);
`endif

        // Random traffic; small rd range keeps register-0 and forwarding matches frequent
        doReset();
        for (int n = 0; n < 400; n++) begin
`ifdef ESC_REG_FWD_EN
            bus.rs_q = 5'($urandom_range(0, 7));
`endif
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 14) == 0),
                          ($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)),
                          32'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
